// File: rtl/i2s_tdm_stream_sender.sv
// i2s_tdm_stream_sender: FIFO-buffered PCM frames serialised MSB-first as I2S (2 channels) or TDM.
// Optional macro SB_I2S_UNDERRUN_REPEAT_EN: an underrun replays the last popped frame instead of silence.
module i2s_tdm_stream_sender #(
    parameter int SAMPLE_W   = 16,
    parameter int CHANNELS   = 2,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BCLK_DIV   = 8
) (
    input  logic                          clk27,
    input  logic                          hw_reset_n,
    input  logic                          enable,
    input  logic                          half_rate,
    input  logic                          flush,
    input  logic [SAMPLE_W*CHANNELS-1:0]  in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          req_tick,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt,
    output logic                          bclk,
    output logic                          lrck,
    output logic                          sdata,
    output logic                          dbg_state
);
    localparam int FB    = SAMPLE_W * CHANNELS;
    localparam int FRAME = CHANNELS * SLOT_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = $clog2(BCLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] B_LAST   = BW'(FRAME - 1);
    localparam logic [BW-1:0] B_HALF   = BW'(FRAME / 2);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_HALF = (AW+1)'(FIFO_DEPTH / 2);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     b_q, b_d;
    logic [FRAME-1:0]  sh_q, sh_d, padded;
    logic [FB-1:0]     frame_q, load_frame, head;
    logic              repeat_q;
    logic              bclk_q, bclk_d, lrck_q, lrck_d, sdata_q, sdata_d;
    logic              req_q, ur_q, ready_q;
    logic [15:0]       ucnt_q;
    logic [AW:0]       wr_q, rd_q, level, lvl_after;
    logic [FB-1:0]     mem [FIFO_DEPTH];

    logic full, empty, wr_en, fall, boundary, start, load, pop_try, do_pop, starve;

    // Write handshake: a frame is taken on any clk27 edge where in_valid and in_ready are both high;
    // in_ready depends only on stored level, so a pop in the same cycle never frees a slot early.
    assign level     = wr_q - rd_q;
    assign full      = (level == LVL_FULL);
    assign empty     = (level == '0);
    assign wr_en     = in_valid && in_ready && !flush;
    assign head      = mem[rd_q[AW-1:0]];

    // Frame boundary is the BCLK falling edge that ends bit FRAME-1; a start from IDLE also loads.
    assign fall      = (state_q == ST_RUN) && (div_q == DIV_LAST);
    assign boundary  = fall && (b_q == B_LAST);
    assign start     = (state_q == ST_IDLE) && enable;
    assign load      = start || (boundary && enable);
    assign pop_try   = load && !repeat_q;
    assign do_pop    = pop_try && !empty && !flush;
    assign starve    = pop_try && !do_pop;
    assign lvl_after = do_pop ? level - 1'b1 : '0;

    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN:  if (boundary && !enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (repeat_q) begin
            load_frame = frame_q;
        end else if (do_pop) begin
            load_frame = head;
        end else begin
`ifdef SB_I2S_UNDERRUN_REPEAT_EN
            load_frame = frame_q;
`else
            load_frame = '0;
`endif
        end
        // Slot k occupies the k-th SLOT_W-bit field from the top, sample MSB first, zero padded.
        padded = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            padded[FRAME-1-k*SLOT_W -: SAMPLE_W] = load_frame[k*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_comb begin
        div_d   = '0;
        b_d     = '0;
        sh_d    = sh_q;
        sdata_d = 1'b0;
        if (state_d == ST_RUN) begin
            div_d   = (fall || start) ? '0 : div_q + 1'b1;
            b_d     = load ? '0 : (fall ? b_q + 1'b1 : b_q);
            sdata_d = start ? 1'b0 : (fall ? sh_q[FRAME-1] : sdata_q);
            sh_d    = load ? padded : (fall ? {sh_q[FRAME-2:0], 1'b0} : sh_q);
        end
        bclk_d = (state_d == ST_RUN) && (div_d >= DIV_HALF);
        lrck_d = (state_d == ST_RUN) && (b_d >= B_HALF);
    end

    always_ff @(posedge clk27 or negedge hw_reset_n) begin
        if (!hw_reset_n) begin
            ready_q  <= 1'b0;
            div_q    <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            bclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            sdata_q  <= 1'b0;
            req_q    <= 1'b0;
            ur_q     <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            frame_q  <= '0;
            repeat_q <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            div_q   <= div_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            bclk_q  <= bclk_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
            req_q   <= pop_try && (lvl_after < LVL_HALF);
            ur_q    <= starve;
            if (flush) begin
                wr_q     <= '0;
                rd_q     <= '0;
                frame_q  <= '0;
                repeat_q <= 1'b0;
                ucnt_q   <= '0;
            end else begin
                if (wr_en) wr_q <= wr_q + 1'b1;
                if (do_pop) begin
                    rd_q    <= rd_q + 1'b1;
                    frame_q <= head;
                end
                if (load) repeat_q <= !repeat_q && do_pop && half_rate;
                if (starve && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk27) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= in_data;
    end

    assign in_ready     = ready_q && !full;
    assign fifo_level   = level;
    assign req_tick     = req_q;
    assign underrun     = ur_q;
    assign underrun_cnt = ucnt_q;
    assign bclk         = bclk_q;
    assign lrck         = lrck_q;
    assign sdata        = sdata_q;
    assign dbg_state    = (state_q == ST_RUN);

endmodule

// File: tb/tb_i2s_tdm_stream_sender.sv
// Bench for i2s_tdm_stream_sender: FIFO table vectors plus frame-level serial reference model.
`timescale 1ns/1ps
module tb_i2s_tdm_stream_sender;
    localparam int SW    = 16;
    localparam int CH    = 2;
    localparam int SLOT  = 32;
    localparam int DEPTH = 16;
    localparam int DIV   = 8;
    localparam int FRAME = CH * SLOT;
    localparam int FB    = SW * CH;
    localparam int CH4   = 4;
    localparam int SLOT4 = 16;

    logic clk27 = 1'b0, hw_reset_n = 1'b0;
    logic enable = 1'b0, half_rate = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [FB-1:0] in_data = '0;
    logic in_ready, req_tick, underrun, bclk, lrck, sdata, dbg_state;
    logic [4:0] fifo_level;
    logic [15:0] underrun_cnt;

    logic d4_enable = 1'b0, d4_valid = 1'b0;
    logic [SW*CH4-1:0] d4_data = '0;
    logic d4_ready, d4_req, d4_ur, d4_bclk, d4_lrck, d4_sdata, d4_dbg;
    logic [4:0] d4_level;
    logic [15:0] d4_cnt;

    i2s_tdm_stream_sender dut (
        .clk27(clk27), .hw_reset_n(hw_reset_n), .enable(enable), .half_rate(half_rate),
        .flush(flush), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fifo_level(fifo_level), .req_tick(req_tick), .underrun(underrun),
        .underrun_cnt(underrun_cnt), .bclk(bclk), .lrck(lrck), .sdata(sdata), .dbg_state(dbg_state)
    );

    i2s_tdm_stream_sender #(.CHANNELS(CH4), .SLOT_W(SLOT4)) dut4 (
        .clk27(clk27), .hw_reset_n(hw_reset_n), .enable(d4_enable), .half_rate(1'b0),
        .flush(1'b0), .in_data(d4_data), .in_valid(d4_valid), .in_ready(d4_ready),
        .fifo_level(d4_level), .req_tick(d4_req), .underrun(d4_ur),
        .underrun_cnt(d4_cnt), .bclk(d4_bclk), .lrck(d4_lrck), .sdata(d4_sdata), .dbg_state(d4_dbg)
    );

    // Clock / reset
    always #18.5 clk27 = ~clk27;

    // Monitors: capture {lrck, sdata} at every BCLK rising edge, count pulses
    logic [1:0] cap_q[$];
    logic [1:0] cap4_q[$];
    logic bclk_p = 1'b0, bclk4_p = 1'b0;
    int cyc = 0, last_rise = 0, rise_gap = 0, ur_seen = 0, tick_seen = 0;

    always @(negedge clk27) begin
        cyc     <= cyc + 1;
        bclk_p  <= bclk;
        bclk4_p <= d4_bclk;
        if (bclk && !bclk_p) begin
            cap_q.push_back({lrck, sdata});
            rise_gap  <= cyc - last_rise;
            last_rise <= cyc;
        end
        if (d4_bclk && !bclk4_p) cap4_q.push_back({d4_lrck, d4_sdata});
        if (underrun) ur_seen <= ur_seen + 1;
        if (req_tick) tick_seen <= tick_seen + 1;
    end

    // Scoreboard state and reference model
    int n_checks = 0, n_fail = 0;
    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] last_pop = '0;
    logic [15:0] ucnt_model = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic bit_of(input logic [127:0] f, input int j, input int slot_w);
        int k, p;
        k = j / slot_w;
        p = j % slot_w;
        if (p >= SW) return 1'b0;
        return f[k*SW + SW - 1 - p];
    endfunction

    function automatic logic [63:0] exp_sdata(input logic [127:0] f, input logic prev, input int slot_w);
        logic [63:0] e;
        e[0] = prev;
        for (int b = 1; b < 64; b++) e[b] = bit_of(f, b - 1, slot_w);
        return e;
    endfunction

    function automatic logic [63:0] exp_lrck(input int slot_w, input int chans);
        logic [63:0] e;
        for (int b = 0; b < 64; b++) e[b] = ((b / slot_w) >= chans / 2);
        return e;
    endfunction

    // Driver tasks
    task automatic push_frame(input logic [FB-1:0] d);
        @(negedge clk27);
        in_data  = d;
        in_valid = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        @(negedge clk27);
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk27);
        flush = 1'b1;
        @(negedge clk27);
        flush = 1'b0;
        exp_q.delete();
        last_pop   = '0;
        ucnt_model = '0;
    endtask

    task automatic run_frames(input int n, input logic h, input string tag);
        logic [FB-1:0] ef[$];
        logic [FB-1:0] cur;
        logic [63:0] got_s, got_l;
        logic rep, prev;
        int exp_ur, exp_tick, ur0, tk0, budget, idx;
        rep = 1'b0; cur = '0; exp_ur = 0; exp_tick = 0;
        for (int i = 0; i < n; i++) begin
            if (rep) begin
                rep = 1'b0;
            end else if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                last_pop = cur;
                if (exp_q.size() < DEPTH / 2) exp_tick++;
                rep = h;
            end else begin
                exp_ur++;
                exp_tick++;
                if (ucnt_model != 16'hFFFF) ucnt_model++;
`ifdef SB_I2S_UNDERRUN_REPEAT_EN
                cur = last_pop;
`else
                cur = '0;
`endif
            end
            ef.push_back(cur);
        end
        ur0 = ur_seen; tk0 = tick_seen;
        cap_q.delete();
        @(negedge clk27);
        half_rate = h;
        enable    = 1'b1;
        budget = 0;
        while (cap_q.size() < (n - 1) * FRAME + 1 && budget < (n + 1) * FRAME * DIV) begin
            @(negedge clk27);
            budget++;
        end
        enable = 1'b0;
        budget = 0;
        while (dbg_state && budget < 2 * FRAME * DIV) begin
            @(negedge clk27);
            budget++;
        end
        repeat (3) @(negedge clk27);
        check({tag, "_bits"}, 64'(cap_q.size()), 64'(n * FRAME));
        prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < FRAME; b++) begin
                idx = i * FRAME + b;
                got_s[b] = (idx < cap_q.size()) ? cap_q[idx][0] : 1'bx;
                got_l[b] = (idx < cap_q.size()) ? cap_q[idx][1] : 1'bx;
            end
            check($sformatf("%s_sdata%0d", tag, i), got_s, exp_sdata({96'b0, ef[i]}, prev, SLOT));
            check($sformatf("%s_lrck%0d", tag, i), got_l, exp_lrck(SLOT, CH));
            prev = bit_of({96'b0, ef[i]}, FRAME - 1, SLOT);
        end
        check({tag, "_underrun_pulses"}, 64'(ur_seen - ur0), 64'(exp_ur));
        check({tag, "_req_ticks"}, 64'(tick_seen - tk0), 64'(exp_tick));
        check({tag, "_level"}, 64'(fifo_level), 64'(exp_q.size()));
        check({tag, "_underrun_cnt"}, 64'(underrun_cnt), 64'(ucnt_model));
        check({tag, "_idle_pins"}, {61'b0, bclk, lrck, sdata}, 64'd0);
    endtask

    typedef struct {
        logic       valid;
        logic       flsh;
        logic       exp_ready;
        logic [4:0] exp_level;
    } vec_t;
    vec_t tbl[20];

    initial begin
        logic [15:0] w_l, w_r;
        logic [63:0] g4_s, g4_l;
        logic [SW*CH4-1:0] f4;
        int nq, nf, budget;
        logic hr;

        for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 5'(i + 1)};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 5'd16};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 5'd0};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 5'd1};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 5'd0};

        // Reset
        repeat (4) @(negedge clk27);
        check("reset_in_ready", {63'b0, in_ready}, 64'd0);
        check("reset_outputs", {40'b0, fifo_level, underrun_cnt, req_tick, underrun, bclk, lrck, sdata},
              64'd0);
        hw_reset_n = 1'b1;
        repeat (2) @(negedge clk27);
        check("post_reset_in_ready", {63'b0, in_ready}, 64'd1);

        // Basic I2S frame: L=A5A5, R=5A5A
        push_frame({16'h5A5A, 16'hA5A5});
        run_frames(1, 1'b0, "basic");
        for (int i = 0; i < 16; i++) begin
            w_l[15-i] = (1 + i < cap_q.size()) ? cap_q[1+i][0] : 1'bx;
            w_r[15-i] = (33 + i < cap_q.size()) ? cap_q[33+i][0] : 1'bx;
        end
        check("basic_left_word", {48'b0, w_l}, 64'h0000_0000_0000_A5A5);
        check("basic_right_word", {48'b0, w_r}, 64'h0000_0000_0000_5A5A);
        check("bclk_period", 64'(rise_gap), 64'(DIV));

        // FIFO fill / full / flush vectors
        for (int i = 0; i < 20; i++) begin
            @(negedge clk27);
            in_data  = FB'($urandom);
            in_valid = tbl[i].valid;
            flush    = tbl[i].flsh;
            check($sformatf("vec%0d_in_ready", i), {63'b0, in_ready}, {63'b0, tbl[i].exp_ready});
            @(posedge clk27);
            #1;
            check($sformatf("vec%0d_level", i), {59'b0, fifo_level}, {59'b0, tbl[i].exp_level});
        end
        @(negedge clk27);
        in_valid = 1'b0;
        flush    = 1'b0;
        exp_q.delete(); last_pop = '0; ucnt_model = '0;

        // Half-rate: 3 frames produce 6
        for (int i = 0; i < 3; i++) push_frame(FB'($urandom));
        run_frames(6, 1'b1, "half_rate");

        // Underrun on empty FIFO, then flush clears the counter
        do_flush();
        run_frames(3, 1'b0, "underrun");
        do_flush();
        check("flush_clears_cnt", 64'(underrun_cnt), 64'd0);

        // Deep FIFO: req_tick only once level drops below half
        for (int i = 0; i < 10; i++) push_frame(FB'($urandom));
        run_frames(3, 1'b0, "deep");

        // Randomised scenarios
        for (int r = 0; r < 3; r++) begin
            do_flush();
            nq = $urandom_range(0, 5);
            hr = 1'($urandom_range(0, 1));
            for (int i = 0; i < nq; i++) push_frame(FB'($urandom));
            nf = nq * (hr ? 2 : 1) + $urandom_range(0, 2);
            if (nf == 0) nf = 1;
            run_frames(nf, hr, $sformatf("rnd%0d", r));
        end

        // TDM: 4 channels, 16-bit slots
        f4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        @(negedge clk27);
        d4_data  = f4;
        d4_valid = 1'b1;
        @(negedge clk27);
        d4_valid = 1'b0;
        cap4_q.delete();
        d4_enable = 1'b1;
        budget = 0;
        while (cap4_q.size() < 1 && budget < 200) begin
            @(negedge clk27);
            budget++;
        end
        d4_enable = 1'b0;
        budget = 0;
        while (d4_dbg && budget < 2 * 64 * DIV) begin
            @(negedge clk27);
            budget++;
        end
        repeat (3) @(negedge clk27);
        check("tdm_bits", 64'(cap4_q.size()), 64'd64);
        for (int b = 0; b < 64; b++) begin
            g4_s[b] = (b < cap4_q.size()) ? cap4_q[b][0] : 1'bx;
            g4_l[b] = (b < cap4_q.size()) ? cap4_q[b][1] : 1'bx;
        end
        check("tdm_sdata", g4_s, exp_sdata({64'b0, f4}, 1'b0, SLOT4));
        check("tdm_lrck", g4_l, exp_lrck(SLOT4, CH4));

        // Reset in the middle of a frame
        do_flush();
        push_frame(FB'($urandom));
        push_frame(FB'($urandom));
        cap_q.delete();
        @(negedge clk27);
        enable = 1'b1;
        budget = 0;
        while (cap_q.size() < 10 && budget < 200) begin
            @(negedge clk27);
            budget++;
        end
        hw_reset_n = 1'b0;
        #1;
        check("midreset_pins", {59'b0, dbg_state, in_ready, bclk, lrck, sdata}, 64'd0);
        check("midreset_level", 64'(fifo_level), 64'd0);
        enable = 1'b0;
        exp_q.delete(); last_pop = '0; ucnt_model = '0;
        @(negedge clk27);
        hw_reset_n = 1'b1;
        repeat (2) @(negedge clk27);
        check("midreset_recover_ready", {63'b0, in_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
